// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the program counter, strobes the program ROM
// (active-low chip enable, address = PC) and latches the returned byte into the
// instruction register. The decoder takes the instruction over IR_VALID/IR_READY.
// JMP reloads the PC and flushes; HALT suppresses new fetches.
// ROM_WAIT is expected to lie in 0..7 (3-bit wait counter).
module fetch_unit #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int RESET_PC = 0,
  parameter int ROM_WAIT = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              CE,
  output logic [ADDR_W-1:0] ABUS,
  input  logic [DATA_W-1:0] DBUS,
  output logic [DATA_W-1:0] IR,
  output logic              IR_VALID,
  input  logic              IR_READY,
  output logic [ADDR_W-1:0] PC,
  input  logic              JMP,
  input  logic [ADDR_W-1:0] JMP_ADDR,
  input  logic              HALT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } state_t;

  // Wait-counter value on the final cycle of a CE low pulse.
  localparam logic [2:0]        WAIT_LAST = 3'(ROM_WAIT);
  localparam logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(RESET_PC);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [2:0]        r_cnt;
  logic              w_last_wait;

  assign w_last_wait = (r_cnt == WAIT_LAST);

  // State register; synchronous reset has priority over every transition.
  always_ff @(posedge CLK) begin
    // NOTE: clocked state always uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: a jump overrides halt and every normal transition.
  always_comb begin
    // NOTE: default first so no path through the block leaves the output
    // unassigned, which would infer a latch.
    w_next_state = r_state;
    if (JMP) begin
      w_next_state = HALT ? S_IDLE : S_FETCH;
    end else begin
      unique case (r_state)
        S_IDLE:  if (!HALT)      w_next_state = S_FETCH;
        S_FETCH: if (w_last_wait) w_next_state = S_VALID;
        S_VALID: if (IR_READY)   w_next_state = HALT ? S_IDLE : S_FETCH;
        default:                 w_next_state = S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    CE       = 1'b1;
    IR_VALID = 1'b0;
    unique case (r_state)
      S_FETCH: CE       = 1'b0;
      S_VALID: IR_VALID = 1'b1;
      default: ;
    endcase
  end

  // PC, instruction register and wait counter. A jump aborts an in-progress
  // read (IR untouched); IR only loads on the edge that ends the CE pulse.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_pc  <= PC_INIT;
      r_ir  <= '0;
      r_cnt <= '0;
    end else if (JMP) begin
      r_pc  <= JMP_ADDR;
      r_cnt <= '0;
    end else if (r_state == S_FETCH) begin
      if (w_last_wait) begin
        r_ir  <= DBUS;
        r_pc  <= r_pc + ADDR_W'(1);
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  // The ROM address is the PC itself, so it is stable for the whole pulse.
  assign ABUS = r_pc;
  assign PC   = r_pc;
  assign IR   = r_ir;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the model computer, directly upstream of the 16×8 program ROM. Holds the program counter, drives the ROM address bus and active-low chip enable, and captures the returned byte into an instruction register. The captured byte is handed to the decoder over a valid/ready handshake. Supports jumps (PC load with flush) and a halt request.

## Interface

**Parameters**
- `ADDR_W`, default 4: ROM address width and PC width.
- `DATA_W`, default 8: ROM data width and IR width.
- `RESET_PC`, default 0: PC value after reset.
- `ROM_WAIT`, default 0: extra cycles the address is held before DBUS is sampled. Range 0–7.

**Ports**
- `CLK` input 1: single clock, rising edge.
- `RST_N` input 1: synchronous, active-low reset.
- `CE` output 1: ROM chip enable, active low.
- `ABUS` output ADDR_W: ROM address, always equal to PC.
- `DBUS` input DATA_W: ROM read data.
- `IR` output DATA_W: instruction register.
- `IR_VALID` output 1: IR holds an untransferred instruction.
- `IR_READY` input 1: decoder accepts IR this cycle.
- `PC` output ADDR_W: program counter, pointing to the next address to fetch.
- `JMP` input 1: load PC from `JMP_ADDR` and flush.
- `JMP_ADDR` input ADDR_W: jump target.
- `HALT` input 1: stop issuing new fetches.

## Operation

**Reset.** Applied while `RST_N` is 0 at a rising edge, with priority over everything. Reset values:
- state = IDLE
- `PC` = `ABUS` = `RESET_PC`
- `CE` = 1
- `IR` = 0
- `IR_VALID` = 0
- wait counter = 0

**State machine.** Moore outputs, decoded from registered state.
- **IDLE**: `CE`=1, `IR_VALID`=0. Go to FETCH if `HALT`=0; otherwise stay.
- **FETCH**: `CE`=0, `ABUS`=`PC`. Lasts `ROM_WAIT`+1 cycles, counted by the wait counter. At the end of the last cycle:
  - `IR` ← `DBUS`
  - `PC` ← `PC`+1, modulo 2^ADDR_W
  - counter ← 0
  - go to VALID
- **VALID**: `CE`=1, `IR_VALID`=1, `IR` stable.
  - On `IR_READY`=1 (transfer), go to FETCH if `HALT`=0, else IDLE.
  - On `IR_READY`=0, hold.

**Jump.** `JMP`=1 in any non-reset cycle has priority over `HALT` and normal transitions.
- `PC` ← `JMP_ADDR`, counter ← 0.
- Next state is FETCH, or IDLE if `HALT`=1.
- In FETCH, the in-progress read is aborted and `IR` is not updated.
- In VALID with `IR_READY`=1, the transfer counts (the decoder has taken `IR`), then the flush applies.
- In VALID with `IR_READY`=0, the instruction is discarded and `IR_VALID` drops next cycle.

**Halt.** Evaluated only on entry to FETCH. It never aborts a fetch already in progress or an instruction already in VALID.

**Arithmetic.** The PC increment wraps: 4'hF → 4'h0. There is no carry-out.

`IR` changes only at FETCH completion or reset.

## Timing

- Fetch latency, measured from the first FETCH cycle to `IR_VALID`=1: `ROM_WAIT`+1 cycles.
- Maximum throughput, with `IR_READY` held at 1: one instruction per `ROM_WAIT`+2 cycles.
- `CE` low pulse width: exactly `ROM_WAIT`+1 cycles per fetch.
- `ABUS` is stable for the whole pulse.
- `DBUS` is sampled at the rising edge that ends the pulse. The ROM is combinational, so its data must settle within `ROM_WAIT`+1 cycles.
- After `RST_N` rises, there is one IDLE cycle before the first FETCH. The first `CE` low occurs in the 2nd cycle after reset release.
- `IR_VALID` falls in the cycle after a transfer or jump.
- `PC` updates on the same edge that loads `IR`, or on the `JMP` edge.
- Reset asserted mid-fetch or mid-VALID: next cycle is IDLE with all reset values; no partial `IR` update.

## Test plan

1. **Sequential fetch.** `ROM_WAIT`=0, ROM preloaded with data[i] = 8'h10+i, `IR_READY`=1, reset then release.
   - Required: `ABUS` steps 0,1,2,… every 2 cycles.
   - Required: `IR` = 8'h10, 8'h11, …
   - Required: after address 4'hF, `PC` wraps to 0 and `IR` = 8'h1F is followed by 8'h10.
2. **Backpressure.** Hold `IR_READY`=0 for 5 cycles after the first `IR_VALID`.
   - Required: `IR`=8'h10 and `IR_VALID`=1 stay stable, `CE` stays 1, `PC`=1.
   - Required: on raising `IR_READY`, the next fetch starts at `ABUS`=1.
3. **Wait states.** `ROM_WAIT`=2.
   - Required: each `CE` low pulse lasts exactly 3 cycles with `ABUS` constant.
   - Required: the period between successive `IR_VALID` rises is 4 cycles.
4. **Jump.**
   - `JMP`=1, `JMP_ADDR`=4'hA during FETCH of address 3: `IR` not loaded from address 3, next `CE` pulse at `ABUS`=4'hA, then `IR`=8'h1A.
   - `JMP` in VALID with `IR_READY`=0: `IR_VALID` drops next cycle and `PC`=4'hA.
5. **Halt.** Assert `HALT` while in VALID holding address 5's data, with `IR_READY`=1.
   - Required: the transfer completes, state goes IDLE, `CE` stays 1 indefinitely, `PC`=6.
   - Required: releasing `HALT` gives `CE` low at `ABUS`=6 the next cycle.
6. **Mid-operation reset.** Drive `RST_N`=0 for one cycle during a `ROM_WAIT`=2 fetch of address 7.
   - Required: the next cycle shows `PC`=`RESET_PC`, `CE`=1, `IR`=0, `IR_VALID`=0.
   - Required: fetching restarts at address 0 after release.
